// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble converter: turns an unsigned binary word into packed BCD
// digits plus a leading-zero blanking mask, one input bit per clock.
module bin_to_bcd_seq #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic [DIGITS-1:0]     digit_en
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam int CAT_W = 4*DIGITS + WIDTH;

  typedef enum logic [0:0] {S_IDLE, S_SHIFT} state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [4*DIGITS-1:0]   r_scratch;
  logic [WIDTH-1:0]      r_shift;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_done;
  logic [4*DIGITS-1:0]   r_bcd;
  logic [DIGITS-1:0]     r_digit_en;

  logic [4*DIGITS-1:0]   w_adj;
  logic [CAT_W-1:0]      w_cat;
  logic [4*DIGITS-1:0]   w_scratch_nxt;
  logic [WIDTH-1:0]      w_shift_nxt;
  logic                  w_last;
  logic                  w_accept;
  logic                  w_finish;

  // Each nibble >= 5 gets +3 independently; no carry crosses a digit boundary.
  function automatic logic [4*DIGITS-1:0] add3_digits(input logic [4*DIGITS-1:0] s);
    logic [4*DIGITS-1:0] r;
    r = s;
    for (int i = 0; i < DIGITS; i++) begin
      if (s[4*i +: 4] >= 4'd5)
        r[4*i +: 4] = s[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

  // Bit i set when digit i or any higher digit is non-zero; ones digit always shown.
  function automatic logic [DIGITS-1:0] blank_mask(input logic [4*DIGITS-1:0] b);
    logic [DIGITS-1:0] m;
    logic              seen;
    m    = '0;
    seen = 1'b0;
    for (int i = DIGITS-1; i >= 0; i--) begin
      seen = seen | (b[4*i +: 4] != 4'd0);
      m[i] = seen;
    end
    m[0] = 1'b1;
    return m;
  endfunction

  assign w_adj         = add3_digits(r_scratch);
  assign w_cat         = {w_adj, r_shift} << 1;
  assign w_scratch_nxt = w_cat[CAT_W-1:WIDTH];
  assign w_shift_nxt   = w_cat[WIDTH-1:0];
  assign w_last        = (r_cnt == CNT_W'(WIDTH - 1));
  assign w_accept      = (r_state == S_IDLE) && start;
  assign w_finish      = (r_state == S_SHIFT) && w_last;

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start)  w_state_nxt = S_SHIFT;
      S_SHIFT: if (w_last) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_scratch  <= '0;
      r_shift    <= '0;
      r_cnt      <= '0;
      r_done     <= 1'b0;
      r_bcd      <= '0;
      r_digit_en <= DIGITS'(1);
    end else begin
      r_done <= w_finish;
      if (w_accept) begin
        r_shift   <= bin_in;
        r_scratch <= '0;
        r_cnt     <= '0;
      end else if (r_state == S_SHIFT) begin
        r_scratch <= w_scratch_nxt;
        r_shift   <= w_shift_nxt;
        r_cnt     <= r_cnt + CNT_W'(1);
      end
      // Outputs only move on completion so the display can read them at any time.
      if (w_finish) begin
        r_bcd      <= w_scratch_nxt;
        r_digit_en <= blank_mask(w_scratch_nxt);
      end
    end
  end

  assign busy     = (r_state == S_SHIFT);
  assign done     = r_done;
  assign bcd_out  = r_bcd;
  assign digit_en = r_digit_en;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed bench for bin_to_bcd_seq: latency, results, blanking mask, ignored start,
// back-to-back conversions and mid-conversion reset.
module tb_bin_to_bcd_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] bin_in;
  logic        busy;
  logic        done;
  logic [19:0] bcd_out;
  logic [4:0]  digit_en;

  int vectors     = 0;
  int miscompares = 0;

  bin_to_bcd_seq #(.WIDTH(16), .DIGITS(5)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .bin_in   (bin_in),
    .busy     (busy),
    .done     (done),
    .bcd_out  (bcd_out),
    .digit_en (digit_en)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called just after an edge; returns edges until done rises (0 on timeout),
  // busy samples including the current one, and whether bcd_out moved early.
  task automatic wait_done(output int edges, output int busy_cnt, output logic moved);
    logic [19:0] held;
    held     = bcd_out;
    moved    = 1'b0;
    edges    = 0;
    busy_cnt = busy ? 1 : 0;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (done) begin
        edges = k;
        break;
      end
      if (busy) busy_cnt++;
      if (bcd_out !== held) moved = 1'b1;
    end
  endtask

  task automatic count_dones(input int cycles, output int n);
    n = 0;
    for (int k = 0; k < cycles; k++) begin
      tick();
      if (done) n++;
    end
  endtask

  task automatic run_conv(input logic [15:0] val, input logic [19:0] exp_bcd,
                          input logic [4:0] exp_en, input string tag);
    int   edges, bcnt;
    logic moved;
    bin_in = val;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    bin_in = ~val;
    wait_done(edges, bcnt, moved);
    chk({tag, "_latency"}, edges, 16);
    chk({tag, "_busy_cycles"}, bcnt, 16);
    chk({tag, "_stable"}, {31'd0, moved}, 0);
    chk({tag, "_bcd"}, {12'd0, bcd_out}, {12'd0, exp_bcd});
    chk({tag, "_en"}, {27'd0, digit_en}, {27'd0, exp_en});
    chk({tag, "_busy_at_done"}, {31'd0, busy}, 0);
    tick();
    chk({tag, "_done_pulse"}, {31'd0, done}, 0);
  endtask

  initial begin
    int   edges, bcnt, n;
    logic moved;
    reset  = 1'b1;
    start  = 1'b0;
    bin_in = '0;
    repeat (3) tick();
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_done", {31'd0, done}, 0);
    chk("rst_bcd", {12'd0, bcd_out}, 0);
    chk("rst_en", {27'd0, digit_en}, 1);
    reset = 1'b0;
    tick();

    run_conv(16'd0,     20'h00000, 5'b00001, "zero");
    run_conv(16'd65535, 20'h65535, 5'b11111, "max");
    run_conv(16'd1234,  20'h01234, 5'b01111, "v1234");
    run_conv(16'd1009,  20'h01009, 5'b01111, "v1009");

    // Second start while busy must be ignored.
    bin_in = 16'd42;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    repeat (4) tick();
    start  = 1'b1;
    bin_in = 16'd999;
    tick();
    start  = 1'b0;
    wait_done(edges, bcnt, moved);
    chk("ign_latency", edges, 11);
    chk("ign_bcd", {12'd0, bcd_out}, 32'h00042);
    chk("ign_en", {27'd0, digit_en}, 32'h3);
    count_dones(20, n);
    chk("ign_single_done", n, 0);
    chk("ign_bcd_hold", {12'd0, bcd_out}, 32'h00042);

    // Start held high: back-to-back conversions every 17 cycles.
    bin_in = 16'd7;
    start  = 1'b1;
    tick();
    bin_in = 16'd80;
    wait_done(edges, bcnt, moved);
    chk("b2b1_latency", edges, 16);
    chk("b2b1_bcd", {12'd0, bcd_out}, 32'h00007);
    chk("b2b1_en", {27'd0, digit_en}, 32'h1);
    tick();
    chk("b2b_restart_busy", {31'd0, busy}, 1);
    chk("b2b_restart_done", {31'd0, done}, 0);
    chk("b2b_restart_bcd", {12'd0, bcd_out}, 32'h00007);
    wait_done(edges, bcnt, moved);
    start = 1'b0;
    chk("b2b2_latency", edges, 16);
    chk("b2b2_stable", {31'd0, moved}, 0);
    chk("b2b2_bcd", {12'd0, bcd_out}, 32'h00080);
    chk("b2b2_en", {27'd0, digit_en}, 32'h3);
    tick();
    chk("b2b_stop_busy", {31'd0, busy}, 0);

    // Reset in the middle of a conversion discards it.
    run_conv(16'd500, 20'h00500, 5'b00111, "v500");
    bin_in = 16'd321;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    repeat (7) tick();
    reset = 1'b1;
    tick();
    chk("mid_rst_busy", {31'd0, busy}, 0);
    chk("mid_rst_done", {31'd0, done}, 0);
    chk("mid_rst_bcd", {12'd0, bcd_out}, 0);
    chk("mid_rst_en", {27'd0, digit_en}, 1);
    reset = 1'b0;
    count_dones(25, n);
    chk("mid_rst_no_done", n, 0);
    chk("mid_rst_bcd_hold", {12'd0, bcd_out}, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
